// File: rtl/mul64_product_accumulator.sv
// mul64_product_accumulator
// Sums a stream of 128-bit unsigned products into a wide accumulator. The
// beat flagged with in_last closes a sequence: its sum, beat count and sticky
// overflow move into a one-entry result buffer drained by a valid/ready port.
module mul64_product_accumulator #(
    parameter int ACC_W = 136,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // Beat counter increment that sticks at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Running sequence state.
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Result buffer.
    buf_state_t       state_q, state_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    // Holds in_ready low during reset and until the first clock after release.
    logic             ready_en_q;

    logic             xfer;
    logic             last_xfer;
    logic [ACC_W:0]   prod_ext;
    logic [ACC_W:0]   sum_ext;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_inc;

    // Ready depends only on control state, never on the incoming beat.
    assign in_ready  = ready_en_q && !clear && ((state_q == BUF_EMPTY) || out_ready);
    assign xfer      = in_valid && in_ready;
    assign last_xfer = xfer && in_last;

    assign out_valid = (state_q == BUF_FULL);
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    // Widened addition: bit ACC_W of the sum is the carry out of the accumulator.
    always_comb begin
        prod_ext        = '0;
        prod_ext[127:0] = in_product;
        sum_ext         = {1'b0, acc_q} + prod_ext;
        cnt_inc         = sat_inc(cnt_q);
        ovf_inc         = ovf_q | sum_ext[ACC_W];
    end

    // Next-state for the running accumulation and the result buffer.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        state_d     = state_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        // clear forces in_ready low, so it never coincides with a transfer.
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (xfer) begin
            if (in_last) begin
                out_sum_d   = sum_ext[ACC_W-1:0];
                out_count_d = cnt_inc;
                out_ovf_d   = ovf_inc;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d = sum_ext[ACC_W-1:0];
                cnt_d = cnt_inc;
                ovf_d = ovf_inc;
            end
        end

        // A last beat arriving while the buffer drains reloads it with no bubble.
        case (state_q)
            BUF_EMPTY: if (last_xfer) state_d = BUF_FULL;
            BUF_FULL:  if (out_ready && !last_xfer) state_d = BUF_EMPTY;
            default:   state_d = BUF_EMPTY;
        endcase
    end

    // State registers; reset wipes any partial sum so it is never emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q  <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            state_q     <= BUF_EMPTY;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            ready_en_q  <= 1'b1;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule
